counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencing controller for the team's 8-bit loadable up counter (DataIn/ENA/LOAD/Count interface). It turns that counter into a programmable interval timer with one-shot and periodic modes, start/stop/pause control, a terminal-count tick and a tick tally.
- The block drives the counter's DataIn, ENA and LOAD, and reads back Count. It never resets the counter; the counter state is always defined by the first load.

Parameters:
- WIDTH, 8, width of the counter datapath and of all value ports.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  launch request; sampled in IDLE and DONE only.
- STOP  in  1  abort request; highest priority after RST.
- PAUSE  in  1  freeze counting while in RUN.
- MODE  in  1  0 = one-shot, 1 = periodic; captured on START.
- START_VAL  in  WIDTH  counter load value; captured on START.
- TERM_VAL  in  WIDTH  terminal count; captured on START.
- CNT_VALUE  in  WIDTH  Count fed back from the counter.
- CNT_DATA  out  WIDTH  to counter DataIn; always equals start_r.
- CNT_ENA  out  1  to counter ENA.
- CNT_LOAD  out  1  to counter LOAD.
- TICK  out  1  one-cycle terminal-count pulse.
- BUSY  out  1  high in LOAD or RUN.
- DONE  out  1  high in DONE.
- TICKS  out  WIDTH  ticks since last START; wraps at 2^WIDTH.

Behaviour:
- Reset:
  - One clock is already decided, with the reset synchronous and active-high.
  - On a rising CLK edge with RST=1: state <= IDLE, start_r <= 0, term_r <= 0, mode_r <= 0, TICKS <= 0.
  - Consequence: CNT_ENA = CNT_LOAD = TICK = BUSY = DONE = 0 and CNT_DATA = 0 from the next cycle.
  - Reset mid-operation aborts immediately with no TICK; the counter holds its last value.
- State register: IDLE, LOAD, RUN, DONE. Outputs are combinational decode of state, PAUSE, STOP and CNT_VALUE; TICKS is registered.
- IDLE:
  - Outputs: CNT_ENA=0, CNT_LOAD=0.
  - START=1 and STOP=0: capture START_VAL, TERM_VAL, MODE; clear TICKS; go to LOAD.
- LOAD:
  - Outputs: CNT_ENA=1, CNT_LOAD=1, so the counter takes start_r at the next edge.
  - Always goes to RUN unless STOP=1.
  - PAUSE is ignored in LOAD.
- RUN, define match = (CNT_VALUE == term_r):
  - PAUSE=1: CNT_ENA=0, no TICK, state held.
  - PAUSE=0, no match: CNT_ENA=1, CNT_LOAD=0; the counter increments and wraps 2^WIDTH-1 -> 0 naturally.
  - PAUSE=0, match, periodic: TICK=1, CNT_ENA=1, CNT_LOAD=1 (reload start_r), TICKS+1, stay in RUN.
  - PAUSE=0, match, one-shot: TICK=1, CNT_ENA=0, TICKS+1, go to DONE.
  - Period for periodic mode:
    - start_r <= term_r: term_r - start_r + 1 cycles.
    - start_r > term_r: 2^WIDTH - start_r + term_r + 1 cycles (passes through wrap).
  - start_r == term_r gives a TICK on every RUN cycle (periodic), or a single TICK on the first RUN cycle (one-shot).
- DONE:
  - Outputs: CNT_ENA=0; the counter holds term_r.
  - START=1 and STOP=0: re-capture inputs and go to LOAD, as from IDLE.
- STOP=1 in LOAD, RUN or DONE:
  - Go to IDLE next cycle.
  - That cycle: CNT_ENA=0, CNT_LOAD=0, TICK suppressed even on match, TICKS unchanged.
- START in LOAD or RUN is ignored; inputs are not re-captured.
- Simultaneous START+STOP in IDLE or DONE: STOP wins and the state goes to or stays in IDLE.
- PAUSE+STOP: STOP wins.
- Changes to START_VAL, TERM_VAL or MODE after capture have no effect until the next accepted START.

Test Plan:
- RST=1 for 2 cycles mid-RUN -> next cycle state IDLE, CNT_ENA=0, CNT_LOAD=0, BUSY=0, TICKS=0, CNT_DATA=0.
- Periodic, START_VAL=3, TERM_VAL=7, START pulse:
  - Expect LOAD for 1 cycle, then CNT_VALUE 3,4,5,6,7,3,...
  - TICK high exactly when CNT_VALUE=7, every 5 cycles.
  - TICKS reads 1,2,3 after three periods.
- One-shot, START_VAL=250, TERM_VAL=2:
  - Expect the count to pass 255->0 and TICK once at CNT_VALUE=2, 9 RUN cycles after LOAD.
  - Then DONE=1, BUSY=0, CNT_ENA=0, counter holds 2.
  - A second START restarts from 250.
- Periodic, START_VAL=TERM_VAL=5 -> TICK high on every RUN cycle; CNT_LOAD=1 each cycle; TICKS increments by 1 per cycle.
- Periodic, 0->9, PAUSE high for 4 cycles at CNT_VALUE=4:
  - CNT_ENA=0 and CNT_VALUE frozen at 4 for those cycles.
  - The period containing the pause is 14 cycles with no TICK during the pause.
- STOP in the cycle CNT_VALUE==TERM_VAL -> no TICK, TICKS unchanged, IDLE next cycle.
- START+STOP together in IDLE -> stays in IDLE.
- START during RUN -> ignored; period unchanged.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencer that turns an external loadable up counter into an interval timer (one-shot / periodic).
// Latency: counter controls and TICK decode combinationally from state and inputs; TICKS updates one clock after TICK.
// Backpressure: none; PAUSE freezes counting in RUN, STOP aborts to IDLE from any active state.
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             MODE,
  input  logic [WIDTH-1:0] START_VAL,
  input  logic [WIDTH-1:0] TERM_VAL,
  input  logic [WIDTH-1:0] CNT_VALUE,
  output logic [WIDTH-1:0] CNT_DATA,
  output logic             CNT_ENA,
  output logic             CNT_LOAD,
  output logic             TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] TICKS
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_term;
  logic             r_mode;
  logic [WIDTH-1:0] r_ticks;

  logic             w_match;
  logic             w_accept;
  logic             w_ena;
  logic             w_load;
  logic             w_tick;

  // A START is only honoured from a resting state, and STOP always overrides it.
  assign w_match  = (CNT_VALUE == r_term);
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && START && !STOP;

  // State register plus captured configuration and tick tally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_start <= '0;
      r_term  <= '0;
      r_mode  <= 1'b0;
      r_ticks <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_start <= START_VAL;
        r_term  <= TERM_VAL;
        r_mode  <= MODE;
        r_ticks <= '0;
      end else if (w_tick) begin
        r_ticks <= r_ticks + WIDTH'(1);
      end
    end
  end

  // Next-state decode; STOP wins over everything except reset.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOAD;
      S_LOAD: w_next = STOP ? S_IDLE : S_RUN;
      S_RUN: begin
        if (STOP)
          w_next = S_IDLE;
        else if (!PAUSE && w_match && !r_mode)
          w_next = S_DONE;
      end
      S_DONE: begin
        if (STOP)
          w_next = S_IDLE;
        else if (w_accept)
          w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; a terminal match in periodic mode reloads in the same cycle so the period stays exact.
  always_comb begin
    w_ena  = 1'b0;
    w_load = 1'b0;
    w_tick = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (!STOP) begin
          w_ena  = 1'b1;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (!STOP && !PAUSE) begin
          if (w_match) begin
            w_tick = 1'b1;
            w_ena  = r_mode;
            w_load = r_mode;
          end else begin
            w_ena = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign CNT_DATA = r_start;
  assign CNT_ENA  = w_ena;
  assign CNT_LOAD = w_load;
  assign TICK     = w_tick;
  assign BUSY     = (r_state == S_LOAD) || (r_state == S_RUN);
  assign DONE     = (r_state == S_DONE);
  assign TICKS    = r_ticks;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl, closing the loop through a model of the 8-bit loadable counter.
// Inputs change 2-3 time units after the rising edge; outputs are sampled before the next edge.
// The counter model is the only feedback path; it never resets, matching the real counter.
module tb_counter_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, STOP, PAUSE, MODE;
  logic [7:0] START_VAL, TERM_VAL;
  logic [7:0] CNT_DATA, TICKS;
  logic       CNT_ENA, CNT_LOAD, TICK, BUSY, DONE;
  logic [7:0] cnt = 8'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  // External loadable up counter: LOAD takes DataIn, otherwise ENA increments.
  always @(posedge CLK) begin
    if (CNT_ENA) cnt <= CNT_LOAD ? CNT_DATA : cnt + 8'd1;
  end

  counter_seq_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .PAUSE(PAUSE), .MODE(MODE),
    .START_VAL(START_VAL), .TERM_VAL(TERM_VAL), .CNT_VALUE(cnt),
    .CNT_DATA(CNT_DATA), .CNT_ENA(CNT_ENA), .CNT_LOAD(CNT_LOAD), .TICK(TICK),
    .BUSY(BUSY), .DONE(DONE), .TICKS(TICKS)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  int last_tick;
  logic [7:0] exp_cnt;

  initial begin
    RST = 1'b1; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; MODE = 1'b0;
    START_VAL = 8'd0; TERM_VAL = 8'd0;
    step(); step();
    RST = 1'b0;
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ena", CNT_ENA, 0);
    check("rst_load", CNT_LOAD, 0);
    check("rst_ticks", TICKS, 0);
    check("rst_data", CNT_DATA, 0);

    // Periodic 3..7, with an ignored START mid-run and a STOP on a match cycle.
    MODE = 1'b1; START_VAL = 8'd3; TERM_VAL = 8'd7; START = 1'b1;
    step();
    START = 1'b0;
    #1;
    check("a_load_busy", BUSY, 1);
    check("a_load_ld", CNT_LOAD, 1);
    check("a_load_ena", CNT_ENA, 1);
    check("a_load_data", CNT_DATA, 3);
    for (int i = 0; i < 19; i++) begin
      step();
      if (i == 6) begin START = 1'b1; START_VAL = 8'd100; TERM_VAL = 8'd50; MODE = 1'b0; end
      if (i == 7) START = 1'b0;
      #1;
      check("a_cnt", cnt, 3 + (i % 5));
      check("a_tick", TICK, (i % 5) == 4);
      check("a_ticks", TICKS, i / 5);
    end
    check("a_data_kept", CNT_DATA, 3);
    step();
    STOP = 1'b1;
    #1;
    check("a_stop_cnt", cnt, 7);
    check("a_stop_tick", TICK, 0);
    check("a_stop_ena", CNT_ENA, 0);
    check("a_stop_ld", CNT_LOAD, 0);
    step();
    STOP = 1'b0;
    #1;
    check("a_idle_busy", BUSY, 0);
    check("a_idle_ticks", TICKS, 3);
    check("a_idle_cnt", cnt, 7);

    // START and STOP together in IDLE: nothing happens, nothing captured.
    START = 1'b1; STOP = 1'b1; START_VAL = 8'd77;
    step();
    START = 1'b0; STOP = 1'b0;
    #1;
    check("b_busy", BUSY, 0);
    check("b_ld", CNT_LOAD, 0);
    check("b_data", CNT_DATA, 3);

    // One-shot 250 -> 2 through the wrap.
    MODE = 1'b0; START_VAL = 8'd250; TERM_VAL = 8'd2; START = 1'b1;
    step();
    START = 1'b0;
    #1;
    check("c_load_ld", CNT_LOAD, 1);
    check("c_ticks_clr", TICKS, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      #1;
      exp_cnt = 8'd250 + 8'(i);
      check("c_cnt", cnt, exp_cnt);
      check("c_tick", TICK, i == 8);
    end
    step();
    #1;
    check("c_done", DONE, 1);
    check("c_busy", BUSY, 0);
    check("c_ena", CNT_ENA, 0);
    check("c_hold", cnt, 2);
    check("c_ticks", TICKS, 1);
    step();
    #1;
    check("c_hold2", cnt, 2);
    check("c_tick_done", TICK, 0);
    START = 1'b1;
    step();
    START = 1'b0;
    #1;
    check("c2_load", CNT_LOAD, 1);
    check("c2_data", CNT_DATA, 250);
    check("c2_ticks", TICKS, 0);
    step();
    #1;
    check("c2_cnt", cnt, 250);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    #1;
    check("c2_idle", BUSY, 0);

    // Periodic with start == term: TICK and reload every RUN cycle.
    MODE = 1'b1; START_VAL = 8'd5; TERM_VAL = 8'd5; START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check("d_cnt", cnt, 5);
      check("d_tick", TICK, 1);
      check("d_ld", CNT_LOAD, 1);
      check("d_ticks", TICKS, i);
    end
    STOP = 1'b1;
    step();
    STOP = 1'b0;

    // Periodic 0..9 with PAUSE for 4 cycles at count 4 in the second period.
    MODE = 1'b1; START_VAL = 8'd0; TERM_VAL = 8'd9; START = 1'b1;
    step();
    START = 1'b0;
    last_tick = -1;
    for (int i = 0; i < 24; i++) begin
      step();
      PAUSE = (i >= 14 && i <= 17);
      #1;
      if (i < 10)       exp_cnt = 8'(i);
      else if (i < 14)  exp_cnt = 8'(i - 10);
      else if (i <= 18) exp_cnt = 8'd4;
      else              exp_cnt = 8'(i - 14);
      check("e_cnt", cnt, exp_cnt);
      check("e_tick", TICK, (i == 9) || (i == 23));
      check("e_ena", CNT_ENA, !(i >= 14 && i <= 17));
      if (i == 23 && last_tick >= 0) check("e_period", i - last_tick, 14);
      if (TICK) last_tick = i;
    end
    PAUSE = 1'b0;

    // Reset for two cycles in the middle of RUN.
    step(); step();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    #1;
    check("f_busy", BUSY, 0);
    check("f_ena", CNT_ENA, 0);
    check("f_ld", CNT_LOAD, 0);
    check("f_ticks", TICKS, 0);
    check("f_data", CNT_DATA, 0);
    check("f_tick", TICK, 0);
    check("f_done", DONE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
